// File: rtl/onchip_mem_pkg.sv
// Shared constants and the Avalon-MM request bundle for the on-chip RAM arbiter.
package onchip_mem_pkg;

  localparam int MEM_ADDR_W = 13;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W   = MEM_DATA_W / 8;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] address;
    logic [MEM_BE_W-1:0]   byteenable;
    logic                  read;
    logic                  write;
    logic [MEM_DATA_W-1:0] writedata;
  } avmm_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input arbiter: one-hot (or zero) grant, round-robin or fixed m0 priority.
module rr_arb2 #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic last_grant;

  // NOTE: grant is defaulted before the case so every path assigns it and no latch is inferred.
  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (ROUND_ROBIN && !last_grant) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  // Resetting to 1 lets m0 win the first conflict.
  always_ff @(posedge clk) begin
    if (reset)
      last_grant <= 1'b1;
    else if (|grant)
      last_grant <= grant[1];
  end

endmodule

// File: rtl/onchip_mem_arbiter2.sv
// Two-master Avalon-MM arbiter in front of a single-port, 1-cycle-latency on-chip RAM.
// Optional perf counters are built when MEMARB_PERF_CNT_EN is defined.
module onchip_mem_arbiter2
  import onchip_mem_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int BE_W        = MEM_BE_W,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  output logic              mem_reset_req,
  input  logic [DATA_W-1:0] mem_readdata
`ifdef MEMARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_grant0,
  output logic [31:0]       perf_grant1,
  output logic [31:0]       perf_conflict
`endif
);

  avmm_req_t  req0, req1, sel;
  logic [1:0] req, grant;
  logic [1:0] rd_pend;

  assign req0 = '{address: m0_address, byteenable: m0_byteenable, read: m0_read,
                  write: m0_write, writedata: m0_writedata};
  assign req1 = '{address: m1_address, byteenable: m1_byteenable, read: m1_read,
                  write: m1_write, writedata: m1_writedata};
  assign req  = {m1_read | m1_write, m0_read | m0_write};

  rr_arb2 #(.ROUND_ROBIN(ROUND_ROBIN)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .grant (grant)
  );

  // With no grant the mux rests on m0, keeping the RAM inputs stable when idle.
  assign sel = grant[1] ? req1 : req0;

  assign mem_address    = sel.address;
  assign mem_byteenable = sel.byteenable;
  assign mem_writedata  = sel.writedata;
  assign mem_chipselect = (|grant) & ~reset;
  assign mem_write      = (|grant) & sel.write & ~reset;
  assign mem_clken      = 1'b1;
  assign mem_reset_req  = reset;

  assign m0_waitrequest = reset | (req[0] & ~grant[0]);
  assign m1_waitrequest = reset | (req[1] & ~grant[1]);

  // A read+write request is handled as a write, so it never returns data.
  always_ff @(posedge clk) begin
    if (reset)
      rd_pend <= 2'b00;
    else
      rd_pend <= grant & {2{sel.read & ~sel.write}};
  end

  // Gating with reset hides a read accepted on the edge just before reset rises.
  assign m0_readdatavalid = rd_pend[0] & ~reset;
  assign m1_readdatavalid = rd_pend[1] & ~reset;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

`ifdef MEMARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_grant0   <= '0;
      perf_grant1   <= '0;
      perf_conflict <= '0;
    end else begin
      perf_grant0   <= perf_grant0 + 32'(grant[0]);
      perf_grant1   <= perf_grant1 + 32'(grant[1]);
      perf_conflict <= perf_conflict + 32'(&req);
    end
  end
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter2.sv
// Directed, table-driven bench: a round-robin and a fixed-priority arbiter share stimulus,
// each in front of its own behavioural RAM.
module tb_onchip_mem_arbiter2;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;

  // round-robin instance
  logic        rr_w0, rr_w1, rr_v0, rr_v1, rr_cs, rr_we, rr_clken, rr_rstreq;
  logic [31:0] rr_rd0, rr_rd1, rr_wd, rr_mem_rdata;
  logic [12:0] rr_addr;
  logic [3:0]  rr_be;
  // fixed-priority instance
  logic        fp_w0, fp_w1, fp_v0, fp_v1, fp_cs, fp_we, fp_clken, fp_rstreq;
  logic [31:0] fp_rd0, fp_rd1, fp_wd, fp_mem_rdata;
  logic [12:0] fp_addr;
  logic [3:0]  fp_be;
`ifdef MEMARB_PERF_CNT_EN
  logic [31:0] rr_pg0, rr_pg1, rr_pc, fp_pg0, fp_pg1, fp_pc;
`endif

  logic [31:0] ram_rr [8192];
  logic [31:0] ram_fp [8192];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter2 #(.ROUND_ROBIN(1'b1)) dut_rr (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(rr_w0),
    .m0_readdata(rr_rd0), .m0_readdatavalid(rr_v0),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(rr_w1),
    .m1_readdata(rr_rd1), .m1_readdatavalid(rr_v1),
    .mem_address(rr_addr), .mem_byteenable(rr_be), .mem_chipselect(rr_cs),
    .mem_write(rr_we), .mem_writedata(rr_wd), .mem_clken(rr_clken),
    .mem_reset_req(rr_rstreq), .mem_readdata(rr_mem_rdata)
`ifdef MEMARB_PERF_CNT_EN
    , .perf_grant0(rr_pg0), .perf_grant1(rr_pg1), .perf_conflict(rr_pc)
`endif
  );

  onchip_mem_arbiter2 #(.ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(fp_w0),
    .m0_readdata(fp_rd0), .m0_readdatavalid(fp_v0),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(fp_w1),
    .m1_readdata(fp_rd1), .m1_readdatavalid(fp_v1),
    .mem_address(fp_addr), .mem_byteenable(fp_be), .mem_chipselect(fp_cs),
    .mem_write(fp_we), .mem_writedata(fp_wd), .mem_clken(fp_clken),
    .mem_reset_req(fp_rstreq), .mem_readdata(fp_mem_rdata)
`ifdef MEMARB_PERF_CNT_EN
    , .perf_grant0(fp_pg0), .perf_grant1(fp_pg1), .perf_conflict(fp_pc)
`endif
  );

  // Behavioural single-port RAMs: byte-masked write, registered read.
  always @(posedge clk) begin
    if (rr_cs && rr_clken) begin
      if (rr_we)
        for (int b = 0; b < 4; b++)
          if (rr_be[b]) ram_rr[rr_addr][8*b +: 8] <= rr_wd[8*b +: 8];
      rr_mem_rdata <= ram_rr[rr_addr];
    end
  end

  always @(posedge clk) begin
    if (fp_cs && fp_clken) begin
      if (fp_we)
        for (int b = 0; b < 4; b++)
          if (fp_be[b]) ram_fp[fp_addr][8*b +: 8] <= fp_wd[8*b +: 8];
      fp_mem_rdata <= ram_fp[fp_addr];
    end
  end

  typedef struct {
    logic        m0_rd, m0_wr;
    logic [12:0] m0_addr;
    logic [3:0]  m0_be;
    logic [31:0] m0_wd;
    logic        m1_rd, m1_wr;
    logic [12:0] m1_addr;
    logic [3:0]  m1_be;
    logic [31:0] m1_wd;
    logic        e_w0, e_w1, e_cs, e_we;
    logic [12:0] e_addr;
    logic        e_v0, e_v1;
    logic [31:0] e_rdata;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, w0, input logic [12:0] a0, input logic [3:0] be0,
                       input logic [31:0] d0, input logic r1, w1, input logic [12:0] a1,
                       input logic [3:0] be1, input logic [31:0] d1);
    m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = d0;
    m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = d1;
  endtask

  task automatic idle();
    drive(0, 0, 13'h0, 4'h0, 32'h0, 0, 0, 13'h0, 4'h0, 32'h0);
  endtask

  initial begin
    // m0 fields | m1 fields | w0 w1 cs we addr | v0 v1 rdata
    vecs[0]  = '{0,0,13'h0000,4'h0,32'h0,        0,0,13'h0000,4'h0,32'h0,        0,0,0,0,13'h0000, 0,0,32'h0};
    vecs[1]  = '{0,1,13'h0010,4'hF,32'hDEADBEEF, 0,0,13'h0000,4'h0,32'h0,        0,0,1,1,13'h0010, 0,0,32'h0};
    vecs[2]  = '{1,0,13'h0010,4'hF,32'h0,        0,0,13'h0000,4'h0,32'h0,        0,0,1,0,13'h0010, 0,0,32'h0};
    vecs[3]  = '{0,0,13'h0000,4'h0,32'h0,        0,0,13'h0000,4'h0,32'h0,        0,0,0,0,13'h0000, 1,0,32'hDEADBEEF};
    vecs[4]  = '{0,0,13'h0000,4'h0,32'h0,        0,1,13'h1FFF,4'hF,32'hFFFFFFFF, 0,0,1,1,13'h1FFF, 0,0,32'h0};
    vecs[5]  = '{0,0,13'h0000,4'h0,32'h0,        0,1,13'h1FFF,4'h5,32'h11223344, 0,0,1,1,13'h1FFF, 0,0,32'h0};
    vecs[6]  = '{0,0,13'h0000,4'h0,32'h0,        1,0,13'h1FFF,4'hF,32'h0,        0,0,1,0,13'h1FFF, 0,0,32'h0};
    vecs[7]  = '{1,0,13'h0010,4'hF,32'h0,        1,0,13'h1FFF,4'hF,32'h0,        0,1,1,0,13'h0010, 0,1,32'hFF22FF44};
    vecs[8]  = '{1,0,13'h0010,4'hF,32'h0,        1,0,13'h1FFF,4'hF,32'h0,        1,0,1,0,13'h1FFF, 1,0,32'hDEADBEEF};
    vecs[9]  = vecs[7];
    vecs[10] = vecs[8];
    vecs[11] = vecs[7];
    vecs[12] = vecs[8];
    vecs[13] = '{0,0,13'h0000,4'h0,32'h0,        0,0,13'h0000,4'h0,32'h0,        0,0,0,0,13'h0000, 0,1,32'hFF22FF44};
    vecs[14] = '{0,1,13'h0020,4'hF,32'hCAFEF00D, 0,0,13'h0000,4'h0,32'h0,        0,0,1,1,13'h0020, 0,0,32'h0};
    vecs[15] = '{0,0,13'h0000,4'h0,32'h0,        1,0,13'h0020,4'hF,32'h0,        0,0,1,0,13'h0020, 0,0,32'h0};
    vecs[16] = '{0,0,13'h0000,4'h0,32'h0,        0,0,13'h0000,4'h0,32'h0,        0,0,0,0,13'h0000, 0,1,32'hCAFEF00D};

    // Reset held 3 cycles with requests pending: everything must stall.
    reset = 1'b1;
    drive(1, 0, 13'h0010, 4'hF, 32'h0, 0, 1, 13'h0001, 4'hF, 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check($sformatf("rst_w0[%0d]", i), 32'(rr_w0), 32'd1);
      check($sformatf("rst_w1[%0d]", i), 32'(rr_w1), 32'd1);
      check($sformatf("rst_cs[%0d]", i), 32'(rr_cs), 32'd0);
      check($sformatf("rst_we[%0d]", i), 32'(rr_we), 32'd0);
      check($sformatf("rst_req[%0d]", i), 32'(rr_rstreq), 32'd1);
    end
    @(negedge clk);
    reset = 1'b0;
    idle();
    #1;
    check("clken", 32'(rr_clken), 32'd1);
    check("rel_rstreq", 32'(rr_rstreq), 32'd0);
    check("rel_v0", 32'(rr_v0), 32'd0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].m0_rd, vecs[i].m0_wr, vecs[i].m0_addr, vecs[i].m0_be, vecs[i].m0_wd,
            vecs[i].m1_rd, vecs[i].m1_wr, vecs[i].m1_addr, vecs[i].m1_be, vecs[i].m1_wd);
      #1;
      check($sformatf("v%0d_w0", i), 32'(rr_w0), 32'(vecs[i].e_w0));
      check($sformatf("v%0d_w1", i), 32'(rr_w1), 32'(vecs[i].e_w1));
      check($sformatf("v%0d_cs", i), 32'(rr_cs), 32'(vecs[i].e_cs));
      check($sformatf("v%0d_we", i), 32'(rr_we), 32'(vecs[i].e_we));
      if (vecs[i].e_cs) check($sformatf("v%0d_addr", i), 32'(rr_addr), 32'(vecs[i].e_addr));
      check($sformatf("v%0d_v0", i), 32'(rr_v0), 32'(vecs[i].e_v0));
      check($sformatf("v%0d_v1", i), 32'(rr_v1), 32'(vecs[i].e_v1));
      if (vecs[i].e_v0) check($sformatf("v%0d_rd0", i), rr_rd0, vecs[i].e_rdata);
      if (vecs[i].e_v1) check($sformatf("v%0d_rd1", i), rr_rd1, vecs[i].e_rdata);
    end
`ifdef MEMARB_PERF_CNT_EN
    check("perf_grant0", rr_pg0, 32'd6);
    check("perf_grant1", rr_pg1, 32'd7);
    check("perf_conflict", rr_pc, 32'd6);
`endif

    // Fixed priority: m0 holds the port for 4 cycles, then m1 gets it.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1, 0, 13'h0010, 4'hF, 32'h0, 1, 0, 13'h1FFF, 4'hF, 32'h0);
      #1;
      check($sformatf("fp_w0[%0d]", i), 32'(fp_w0), 32'd0);
      check($sformatf("fp_w1[%0d]", i), 32'(fp_w1), 32'd1);
      if (i > 0) begin
        check($sformatf("fp_v0[%0d]", i), 32'(fp_v0), 32'd1);
        check($sformatf("fp_rd0[%0d]", i), fp_rd0, 32'hDEADBEEF);
      end
    end
    @(negedge clk);
    drive(0, 0, 13'h0, 4'h0, 32'h0, 1, 0, 13'h1FFF, 4'hF, 32'h0);
    #1;
    check("fp_w1_after", 32'(fp_w1), 32'd0);
    check("fp_v0_last", 32'(fp_v0), 32'd1);
    @(negedge clk);
    idle();
    #1;
    check("fp_v1", 32'(fp_v1), 32'd1);
    check("fp_rd1", fp_rd1, 32'hFF22FF44);
    check("fp_v0_off", 32'(fp_v0), 32'd0);

    // Reset right after an accepted read: its readdatavalid must never appear.
    @(negedge clk);
    drive(1, 0, 13'h0010, 4'hF, 32'h0, 0, 0, 13'h0, 4'h0, 32'h0);
    #1;
    check("mr_accept_w0", 32'(rr_w0), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle();
    #1;
    check("mr_v0_a", 32'(rr_v0), 32'd0);
    @(negedge clk);
    drive(1, 0, 13'h0010, 4'hF, 32'h0, 0, 0, 13'h0, 4'h0, 32'h0);
    #1;
    check("mr_w0_rst", 32'(rr_w0), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    idle();
    #1;
    check("mr_v0_b", 32'(rr_v0), 32'd0);
    check("mr_cs", 32'(rr_cs), 32'd0);
`ifdef MEMARB_PERF_CNT_EN
    check("mr_pg0", rr_pg0, 32'd0);
    check("mr_pg1", rr_pg1, 32'd0);
    check("mr_pc", rr_pc, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter2.md
Name: onchip_mem_arbiter2

Overview:
- Two-master Avalon-MM arbiter placed directly upstream of one single-port on-chip RAM slave.
- Sits between a core's data master (m0) and the inter-core DMA/mailbox master (m1).
- Serialises both onto the RAM's single port (13-bit word address, 32-bit data, byte enables, 1-cycle read latency).
- Returns readdatavalid to the issuing master.

Parameters:
- ADDR_W, 13, word address width (8192 words)
- DATA_W, 32, data width
- BE_W, 4, byte-enable width (DATA_W/8)
- ROUND_ROBIN, 1, 1 = round-robin arbitration; 0 = fixed priority, m0 wins

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_address  in  ADDR_W  master 0 word address
- m0_byteenable  in  BE_W  master 0 byte enables
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_writedata  in  DATA_W  master 0 write data
- m0_waitrequest  out  1  master 0 stall
- m0_readdata  out  DATA_W  master 0 read data
- m0_readdatavalid  out  1  master 0 read data valid
- m1_*  same seven signals as m0_*, for master 1
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  BE_W  to RAM byteenable
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_W  to RAM writedata
- mem_clken  out  1  RAM clock enable, constant 1
- mem_reset_req  out  1  RAM reset_req, equals reset
- mem_readdata  in  DATA_W  RAM readdata, valid 1 cycle after address is accepted

Behaviour:
- Request definition: reqN = mN_read | mN_write. A master asserting both read and write in the same cycle is illegal; behaviour is then treated as a write.
- Grant logic:
  - grant is combinational each cycle and one-hot or zero.
  - Only one master requests: that master is granted.
  - Both request, ROUND_ROBIN=1: grant the master not in last_grant.
  - Both request, ROUND_ROBIN=0: grant m0.
- last_grant register:
  - 1 bit, updated on every cycle with a grant.
  - Reset value = 1, so m0 wins the first conflict.
- Waitrequest: mN_waitrequest = reset | (reqN & ~grantN). Combinational; the transaction completes on the edge where the request is high and waitrequest is low.
- Memory side, combinational from the granted master:
  - mem_address, mem_byteenable and mem_writedata are muxed from the granted master; they are held at m0's values when there is no grant.
  - mem_chipselect = |grant & ~reset.
  - mem_write = granted write & ~reset.
- Read return:
  - Registers rd_pend[1:0] <= {grant1 & m1_read, grant0 & m0_read}.
  - mN_readdatavalid = rd_pend[N].
  - mN_readdata = mem_readdata, unconditionally; masters qualify it with readdatavalid.
  - Latency from accepted read to readdatavalid is exactly 1 cycle.
  - Throughput is one transaction per cycle; back-to-back reads from alternating masters are fully pipelined.
- Reset:
  - rd_pend = 0, last_grant = 1.
  - All waitrequests are high and mem_chipselect is 0 while reset is high.
  - A read accepted in the cycle before reset asserts has its readdatavalid suppressed (rd_pend is cleared).
- Boundary conditions:
  - Write and read to the same address in consecutive cycles by different masters: the read returns the new data, because the RAM port is sequential.
  - Address wrap is not applicable; the full ADDR_W range is legal.

Optional Feature:
- Macro: MEMARB_PERF_CNT_EN.
- Defined: adds outputs perf_grant0, perf_grant1 and perf_conflict, each 32 bits.
  - perf_grant0 / perf_grant1 count grants to each master.
  - perf_conflict counts cycles in which both masters request.
  - All counters wrap at 2^32, are cleared by reset, and are frozen while reset is high.
- Undefined: these ports and counters are absent; the remaining logic is identical.

Decomposition:
- Package onchip_mem_pkg holds:
  - constants MEM_ADDR_W=13, MEM_DATA_W=32, MEM_BE_W=4;
  - typedef avmm_req_t {address, byteenable, read, write, writedata}.
- One sub-module, rr_arb2: 2-input arbiter holding last_grant and the ROUND_ROBIN mode, producing the one-hot grant.
- Muxing, rd_pend and the counters stay in the top module.

Test Plan:
- Reset release: hold reset 3 cycles, then idle → all waitrequests drop to 0 when not requesting; mem_chipselect=0; no readdatavalid.
- Single master: m0 writes 0xDEADBEEF to 0x0010 with byteenable=4'hF, then reads 0x0010 → m0_waitrequest=0 on both; m0_readdatavalid high 1 cycle after the read; m0_readdata=0xDEADBEEF.
- Conflict, round-robin: both masters read every cycle for 6 cycles → grants alternate m0,m1,m0,m1,...; readdatavalid alternates with 1-cycle lag; perf_conflict=6.
- Fixed priority (ROUND_ROBIN=0): both masters request for 4 cycles → m0 granted 4 times; m1_waitrequest high for all 4; m1 is granted in the cycle after m0 drops.
- Byte enables: m1 writes 0x11223344 with byteenable=4'b0101 over 0xFFFFFFFF at 0x1FFF, then reads it → data=0xFF22FF44.
- Reset mid-read: m0 read accepted, reset asserted on the next edge → m0_readdatavalid stays 0; after reset, perf counters (if enabled) read 0.
